// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: requester/FIFO-side signals of the two-requester FIFO write arbiter.
interface fifo_wr_arb_if #(parameter int DATA_W = 8);
  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              fifo_full;
  logic              gnt0;
  logic              gnt1;
  logic              fifo_we;
  logic [DATA_W-1:0] fifo_wdata;
  modport master (
    output req0, req1, wdata0, wdata1, fifo_full,
    input  gnt0, gnt1, fifo_we, fifo_wdata
  );
  modport slave (
    input  req0, req1, wdata0, wdata1, fifo_full,
    output gnt0, gnt1, fifo_we, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: two-requester FIFO write arbiter, Moore grants, burst-limited round robin.
module fifo_wr_arb #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic         clk,
  input logic         rst,
  fifo_wr_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  localparam logic [3:0] MAX = 4'(MAX_BURST);
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       last, last_n;
  logic       xfer, limit;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
    end
  end
  // rst gates the combinational outputs so nothing is written in the reset cycle
  always_comb begin
    xfer  = ((state == G0 && bus.req0) || (state == G1 && bus.req1)) && !bus.fifo_full && !rst;
    limit = xfer && (cnt + 4'd1 == MAX);
    state_n = state;
    case (state)
      IDLE:    state_n = (bus.req0 && (!bus.req1 || last)) ? G0 : bus.req1 ? G1 : IDLE;
      G0:      state_n = !bus.req0 ? (bus.req1 ? G1 : IDLE) : (limit && bus.req1) ? G1 : G0;
      G1:      state_n = !bus.req1 ? (bus.req0 ? G0 : IDLE) : (limit && bus.req0) ? G0 : G1;
      default: state_n = IDLE;
    endcase
    cnt_n  = (state_n != state || limit) ? 4'd0 : xfer ? cnt + 4'd1 : cnt;
    last_n = (state_n != state && state_n == G0) ? 1'b0 :
             (state_n != state && state_n == G1) ? 1'b1 : last;
    bus.gnt0       = state == G0 && !rst;
    bus.gnt1       = state == G1 && !rst;
    bus.fifo_we    = xfer;
    bus.fifo_wdata = rst ? {DATA_W{1'b0}} : state == G0 ? bus.wdata0 :
                     state == G1 ? bus.wdata1 : {DATA_W{1'b0}};
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed cycle-by-cycle checks of fifo_wr_arb with MAX_BURST=4.
module tb_fifo_wr_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  localparam logic [7:0] D0 = 8'hA5;
  localparam logic [7:0] D1 = 8'h3C;
  fifo_wr_arb_if #(.DATA_W(8)) bus ();
  fifo_wr_arb #(.DATA_W(8), .MAX_BURST(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc(input logic rs, input logic r0, input logic r1, input logic full);
    @(posedge clk);
    #1;
    rst = rs;
    bus.req0 = r0;
    bus.req1 = r1;
    bus.fifo_full = full;
    #1;
  endtask
  task automatic chk(input string tag, input logic g0, input logic g1, input logic we, input logic [7:0] d);
    tests += 4;
    assert (bus.gnt0 === g0) else begin fails++; $error("FAIL %s gnt0 got %0b exp %0b", tag, bus.gnt0, g0); end
    assert (bus.gnt1 === g1) else begin fails++; $error("FAIL %s gnt1 got %0b exp %0b", tag, bus.gnt1, g1); end
    assert (bus.fifo_we === we) else begin fails++; $error("FAIL %s fifo_we got %0b exp %0b", tag, bus.fifo_we, we); end
    assert (bus.fifo_wdata === d) else begin fails++; $error("FAIL %s fifo_wdata got %h exp %h", tag, bus.fifo_wdata, d); end
  endtask
  always @(negedge clk) begin
    tests += 3;
    assert (!(bus.gnt0 && bus.gnt1)) else begin fails++; $error("FAIL both_gnt got 1 exp 0"); end
    assert (!(bus.fifo_we && bus.fifo_full)) else begin fails++; $error("FAIL we_full got 1 exp 0"); end
    assert (!bus.fifo_we || (bus.gnt0 ^ bus.gnt1)) else begin fails++; $error("FAIL we_owner got %0b%0b exp one grant", bus.gnt0, bus.gnt1); end
  end
  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.fifo_full = 1'b0;
    bus.wdata0 = D0;
    bus.wdata1 = D1;
    cyc(1, 1, 1, 0); chk("rst_hold", 0, 0, 0, 8'h00);
    cyc(1, 1, 1, 0); chk("rst_hold2", 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0); chk("post_rst", 0, 0, 0, 8'h00);
    // alternating bursts with both requesting
    cyc(0, 1, 1, 0); chk("idle_both", 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin cyc(0, 1, 1, 0); chk("alt_g0", 1, 0, 1, D0); end
    for (int i = 0; i < 4; i++) begin cyc(0, 1, 1, 0); chk("alt_g1", 0, 1, 1, D1); end
    cyc(0, 1, 1, 0); chk("alt_g0_again", 1, 0, 1, D0);
    cyc(0, 0, 0, 0); chk("g0_drop", 1, 0, 0, D0);
    cyc(0, 0, 0, 0); chk("to_idle", 0, 0, 0, 8'h00);
    // lone requester keeps the grant past the burst limit
    cyc(0, 0, 1, 0); chk("r1_idle", 0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin cyc(0, 0, 1, 0); chk("r1_only", 0, 1, 1, D1); end
    cyc(0, 0, 0, 0); chk("g1_drop", 0, 1, 0, D1);
    cyc(0, 0, 0, 0); chk("to_idle2", 0, 0, 0, 8'h00);
    // stall mid-burst: limit counts transfers, not cycles
    cyc(0, 1, 1, 0); chk("tie_idle", 0, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) begin cyc(0, 1, 1, 0); chk("stall_pre", 1, 0, 1, D0); end
    for (int i = 0; i < 3; i++) begin cyc(0, 1, 1, 1); chk("stall_full", 1, 0, 0, D0); end
    for (int i = 0; i < 2; i++) begin cyc(0, 1, 1, 0); chk("stall_post", 1, 0, 1, D0); end
    cyc(0, 1, 1, 0); chk("stall_rot", 0, 1, 1, D1);
    // req1 drops after two G1 transfers; G0 burst starts from zero
    cyc(0, 1, 1, 0); chk("g1_xfer2", 0, 1, 1, D1);
    cyc(0, 1, 0, 0); chk("g1_req_low", 0, 1, 0, D1);
    cyc(0, 1, 0, 0); chk("g0_take", 1, 0, 1, D0);
    for (int i = 0; i < 3; i++) begin cyc(0, 1, 1, 0); chk("g0_fresh", 1, 0, 1, D0); end
    cyc(0, 1, 1, 0); chk("g0_fresh_rot", 0, 1, 1, D1);
    for (int i = 0; i < 3; i++) begin cyc(0, 1, 1, 0); chk("g1_run", 0, 1, 1, D1); end
    for (int i = 0; i < 2; i++) begin cyc(0, 1, 1, 0); chk("g0_pre_rst", 1, 0, 1, D0); end
    // reset mid-burst
    cyc(1, 1, 1, 0); chk("rst_mid", 0, 0, 0, 8'h00);
    cyc(0, 1, 1, 0); chk("rst_idle", 0, 0, 0, 8'h00);
    cyc(0, 1, 1, 0); chk("rst_g0_first", 1, 0, 1, D0);
    cyc(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DATA_W, default 8: width of every data path.
REQ-002 Parameter MAX_BURST, default 4, legal range 1..15: maximum transfers per grant while the other requester waits.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req0  input  1  requester 0 has a word to write.
REQ-006 wdata0  input  DATA_W  requester 0 write data.
REQ-007 req1  input  1  requester 1 has a word to write.
REQ-008 wdata1  input  DATA_W  requester 1 write data.
REQ-009 fifo_full  input  1  downstream FIFO full flag.
REQ-010 gnt0  output  1  requester 0 owns the FIFO write port.
REQ-011 gnt1  output  1  requester 1 owns the FIFO write port.
REQ-012 fifo_we  output  1  FIFO write enable.
REQ-013 fifo_wdata  output  DATA_W  FIFO write data.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, G0, G1; gnt0 = (state==G0), gnt1 = (state==G1), both registered (Moore), never both high.
REQ-015 A transfer SHALL occur in a cycle iff (G0 & req0 | G1 & req1) & !fifo_full; fifo_we SHALL be high exactly in transfer cycles (combinational, same cycle).
REQ-016 fifo_wdata SHALL be wdata0 in G0, wdata1 in G1, all-zero in IDLE.
REQ-017 A 4-bit burst counter SHALL increment on each transfer and clear on every state change.
REQ-018 A last-served flag SHALL record the most recent granted requester (0 or 1), updated on entry to G0/G1.
REQ-019 IDLE: req0 only -> G0; req1 only -> G1; both -> requester not last-served; neither -> stay IDLE.
REQ-020 Gn with req_n low: -> G(other) if other requester's req high, else IDLE.
REQ-021 Gn, transfer this cycle, and counter reaches MAX_BURST: -> G(other) if other req high; else stay Gn with counter cleared.
REQ-022 Gn, otherwise: stay Gn.
REQ-023 fifo_full high SHALL stall: no transfer, counter held, grant held; burst limit is counted in transfers, not cycles.
REQ-024 Grant transitions SHALL take one cycle: first transfer of a new owner occurs no earlier than the cycle after grant registration; no cycle carries two owners.
REQ-025 Requesters SHALL hold reqN and wdataN stable until a cycle with gntN & !fifo_full; the block does not buffer data.

Reset
REQ-026 rst high at a clock edge SHALL force state IDLE, counter 0, last-served = 1 (requester 0 wins first tie).
REQ-027 During and after reset until next grant: gnt0=0, gnt1=0, fifo_we=0, fifo_wdata=0.
REQ-028 Reset mid-burst SHALL abandon the burst; no write is issued in the reset cycle.

Verification
REQ-029 Post-reset, req0=req1=1, fifo_full=0, MAX_BURST=4 -> gnt0 next cycle, 4 writes of wdata0, then gnt1 for 4 writes, alternating.
REQ-030 Only req1=1 held 10 cycles -> gnt1 one cycle after req, 10 consecutive writes of wdata1, grant never rotates.
REQ-031 G0 active, fifo_full=1 for 3 cycles mid-burst -> fifo_we=0 those cycles, gnt0 held, burst finishes after 4 total transfers.
REQ-032 G1 active, req1 drops after 2 transfers, req0=1 -> next cycle gnt0, counter restarts at 0.
REQ-033 rst asserted during G0 after 2 transfers -> next cycle all outputs 0, state IDLE; with both requesting afterwards, gnt0 first.
REQ-034 Checkers across all runs: gnt0 & gnt1 never both 1; fifo_we implies !fifo_full; fifo_we implies exactly one grant.
